// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : mux_pkg
// Brief  : Shared state encoding and width helper for the mux_pipe slice.
// Rev    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_SKID  = 2'd2;

    // Number of bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module : mux_n
// Brief  : Combinational N:1 word selector; out-of-range select yields zero.
// Rev    : 1.0 - initial release
// ============================================================================
module mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data
);

    logic [WIDTH-1:0] w_words [NUM_IN];

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_word
            assign w_words[gi] = i_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Only exact index matches drive the output, so unused codes fall to zero.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = w_words[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_pipe.sv
`default_nettype none
// ============================================================================
// Module : mux_pipe
// Brief  : N-way registered selector with valid/ready and a 2-entry skid.
//          Define MUX_PIPE_SEL_ERR_EN to carry an out-of-range flag per beat.
// Rev    : 1.0 - initial release
// ============================================================================
module mux_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_push;
    logic             w_pop;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux_n (
        .i_data (in_data),
        .i_sel  (in_sel),
        .o_data (w_sel_data)
    );

    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main_data;
    assign in_ready  = r_in_ready;
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_next_state = S_FULL;
            S_FULL: begin
                if (w_push && !w_pop)      w_next_state = S_SKID;
                else if (!w_push && w_pop) w_next_state = S_EMPTY;
            end
            S_SKID:  if (w_pop) w_next_state = S_FULL;
            default: w_next_state = S_EMPTY;
        endcase
    end

    // in_ready comes straight from a flop so upstream never sees our out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_SKID);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) r_main_data <= w_sel_data;
                S_FULL: begin
                    if (w_push && w_pop) r_main_data <= w_sel_data;
                    else if (w_push)     r_skid_data <= w_sel_data;
                end
                S_SKID:  if (w_pop) r_main_data <= r_skid_data;
                default: ;
            endcase
        end
    end

`ifdef MUX_PIPE_SEL_ERR_EN
    logic w_sel_err;
    logic r_main_err;
    logic r_skid_err;

    assign w_sel_err = (int'(in_sel) >= NUM_IN);

    // Error flag follows exactly the same path as its data word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_err <= 1'b0;
            r_skid_err <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) r_main_err <= w_sel_err;
                S_FULL: begin
                    if (w_push && w_pop) r_main_err <= w_sel_err;
                    else if (w_push)     r_skid_err <= w_sel_err;
                end
                S_SKID:  if (w_pop) r_main_err <= r_skid_err;
                default: ;
            endcase
        end
    end

    assign out_err = r_main_err;
`else
    assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_pipe
// Brief  : Scoreboard bench for mux_pipe (NUM_IN=4 main DUT, NUM_IN=3 for range).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mux_pipe;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_err;

    logic [95:0]  d3_in_data;
    logic [1:0]   d3_sel;
    logic         d3_valid;
    logic         d3_ready;
    logic [31:0]  d3_out_data;
    logic         d3_out_valid;
    logic         d3_out_ready;
    logic         d3_out_err;

    int           n_tests;
    int           n_fail;
    logic [31:0]  q_exp [$];
    logic         r_prev_stall;
    logic         r_prev_acc;
    logic [31:0]  r_prev_data;
    logic [63:0]  c_exp_err;

    mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (d3_in_data),
        .in_sel    (d3_sel),
        .in_valid  (d3_valid),
        .in_ready  (d3_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_err   (d3_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, update scoreboard, then advance past posedge.
    task automatic tick();
        logic [31:0] exp;
        @(negedge clk);
        if (!rst_n) begin
            q_exp.delete();
            r_prev_stall = 1'b0;
            r_prev_acc   = 1'b0;
        end else begin
            if (r_prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(r_prev_data));
            end
            if (r_prev_acc) chk("latency", 64'(out_valid), 64'd1);
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("sb_nonempty_on_pop", 64'(q_exp.size()), 64'd1);
                end else begin
                    exp = q_exp.pop_front();
                    chk("data", 64'(out_data), 64'(exp));
                    chk("err", 64'(out_err), 64'd0);
                end
            end
            r_prev_stall = out_valid && !out_ready;
            r_prev_data  = out_data;
            r_prev_acc   = in_valid && in_ready;
            if (in_valid && in_ready) q_exp.push_back(in_data[in_sel*32 +: 32]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        r_prev_stall = 1'b0;
        r_prev_acc   = 1'b0;
        r_prev_data  = '0;
`ifdef MUX_PIPE_SEL_ERR_EN
        c_exp_err = 64'd1;
`else
        c_exp_err = 64'd0;
`endif
        rst_n        = 1'b0;
        in_data      = '0;
        in_sel       = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        d3_in_data   = '0;
        d3_sel       = '0;
        d3_valid     = 1'b0;
        d3_out_ready = 1'b1;

        // Reset
        repeat (2) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_d3_valid", 64'(d3_out_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        // Streaming sel 0..3
        in_data = {32'hD, 32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 4; i++) begin
            in_sel   = 2'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_drained", 64'(q_exp.size()), 64'd0);

        // Stall with two buffered beats
        out_ready = 1'b0;
        in_sel    = 2'd1;
        in_data   = {4{32'h11}};
        in_valid  = 1'b1;
        tick();
        in_data = {4{32'h22}};
        tick();
        in_valid = 1'b0;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("stall_in_ready_hold", 64'(in_ready), 64'd0);
        chk("stall_head", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        tick();
        tick();
        chk("stall_in_ready_back", 64'(in_ready), 64'd1);
        chk("stall_drained", 64'(q_exp.size()), 64'd0);
        repeat (2) tick();

        // Out-of-range select on the 3-input instance
        d3_in_data = {32'h3C, 32'h2B, 32'h1A};
        d3_sel     = 2'd3;
        d3_valid   = 1'b1;
        tick();
        chk("oor_valid", 64'(d3_out_valid), 64'd1);
        chk("oor_data", 64'(d3_out_data), 64'd0);
        chk("oor_err", 64'(d3_out_err), c_exp_err);
        d3_sel = 2'd2;
        tick();
        d3_valid = 1'b0;
        chk("inrange_data", 64'(d3_out_data), 64'h3C);
        chk("inrange_err", 64'(d3_out_err), 64'd0);
        tick();
        chk("d3_idle", 64'(d3_out_valid), 64'd0);

        // Reset while in SKID drops both beats
        out_ready = 1'b0;
        in_sel    = 2'd2;
        in_data   = {4{32'h33}};
        in_valid  = 1'b1;
        tick();
        in_data = {4{32'h44}};
        tick();
        in_valid = 1'b0;
        chk("skid_entered", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("skid_rst_valid", 64'(out_valid), 64'd0);
        chk("skid_rst_ready", 64'(in_ready), 64'd1);
        chk("skid_rst_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("skid_rst_quiet", 64'(out_valid), 64'd0);
        end

        // Random traffic; upstream holds its beat while not accepted
        for (int i = 0; i < 500; i++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (q_exp.size() != 0 || out_valid) tick();
        end
        chk("final_drained", 64'(q_exp.size()), 64'd0);
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
